// File: rtl/dbus_wb_if_pkg.sv
// Shared definitions for the data-side Wishbone bus interface:
// FSM state encodings and the common control/data constants.
package dbus_wb_if_pkg;

    typedef enum logic [1:0] {
        IDLE           = 2'b00,
        BUSY           = 2'b01,
        WAIT_FOR_STALL = 2'b10
    } dbus_state_e;

    localparam logic        STOP          = 1'b1;
    localparam logic        NO_STOP       = 1'b0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/dbus_wb_if.sv
// MEM-stage to Wishbone data bus bridge: one bus cycle per request, stall while outstanding.
// Define DBUS_ERR_EN to add wb_err_i/bus_err_o slave-error termination.
module dbus_wb_if
    import dbus_wb_if_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        stall_i,
    input  logic              flush_i,
    input  logic              cpu_ce_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [SEL_W-1:0]  cpu_sel_i,
    input  logic [DATA_W-1:0] cpu_data_i,
    output logic [DATA_W-1:0] cpu_data_o,
    output logic              stallreq_o,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [DATA_W-1:0] wb_dat_o,
    input  logic [DATA_W-1:0] wb_dat_i,
    output logic              wb_we_o,
    output logic [SEL_W-1:0]  wb_sel_o,
    output logic              wb_stb_o,
    output logic              wb_cyc_o,
    input  logic              wb_ack_i
`ifdef DBUS_ERR_EN
    ,
    input  logic              wb_err_i,
    output logic              bus_err_o
`endif
);

    dbus_state_e       state, state_nxt;
    logic [ADDR_W-1:0] adr_nxt;
    logic [DATA_W-1:0] dat_nxt;
    logic              we_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic              stb_nxt;
    logic              cyc_nxt;
    logic [DATA_W-1:0] rd_buf, rd_buf_nxt;
    logic              drop_bus;
    logic              err;

`ifdef DBUS_ERR_EN
    assign err       = wb_err_i;
    assign bus_err_o = (state == BUSY) && !flush_i && wb_err_i;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_we_o  <= WRITE_DISABLE;
            wb_sel_o <= '0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            rd_buf   <= '0;
        end else begin
            state    <= state_nxt;
            wb_adr_o <= adr_nxt;
            wb_dat_o <= dat_nxt;
            wb_we_o  <= we_nxt;
            wb_sel_o <= sel_nxt;
            wb_stb_o <= stb_nxt;
            wb_cyc_o <= cyc_nxt;
            rd_buf   <= rd_buf_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        adr_nxt    = wb_adr_o;
        dat_nxt    = wb_dat_o;
        we_nxt     = wb_we_o;
        sel_nxt    = wb_sel_o;
        stb_nxt    = wb_stb_o;
        cyc_nxt    = wb_cyc_o;
        rd_buf_nxt = rd_buf;
        drop_bus   = 1'b0;
        stallreq_o = NO_STOP;
        cpu_data_o = '0;

        case (state)
            IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    adr_nxt    = cpu_addr_i;
                    dat_nxt    = cpu_we_i ? cpu_data_i : '0;
                    we_nxt     = cpu_we_i;
                    sel_nxt    = cpu_sel_i;
                    stb_nxt    = 1'b1;
                    cyc_nxt    = 1'b1;
                    state_nxt  = BUSY;
                    stallreq_o = STOP;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    drop_bus  = 1'b1;
                    state_nxt = IDLE;
                end else if (err) begin
                    drop_bus   = 1'b1;
                    rd_buf_nxt = '0;
                    state_nxt  = IDLE;
                end else if (wb_ack_i) begin
                    drop_bus = 1'b1;
                    if (wb_we_o == WRITE_DISABLE) begin
                        rd_buf_nxt = wb_dat_i;
                        cpu_data_o = wb_dat_i;
                    end
                    state_nxt = (stall_i != '0) ? WAIT_FOR_STALL : IDLE;
                end else begin
                    stallreq_o = STOP;
                end
            end
            WAIT_FOR_STALL: begin
                // Hold the returned load data until the pipeline can accept it.
                cpu_data_o = rd_buf;
                if (flush_i || stall_i == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                drop_bus  = 1'b1;
                state_nxt = IDLE;
            end
        endcase

        if (drop_bus) begin
            adr_nxt = '0;
            dat_nxt = '0;
            we_nxt  = WRITE_DISABLE;
            sel_nxt = '0;
            stb_nxt = 1'b0;
            cyc_nxt = 1'b0;
        end
    end

endmodule
